store_buffer: RTL



---
 rtl/store_buffer_pkg.sv | 17 +
 rtl/sb_align.sv | 39 +++
 rtl/store_buffer.sv | 106 ++++++++++
 3 files changed

// File: rtl/store_buffer_pkg.sv
// Shared store-buffer types and the lane-mask encodings used by
// the core's store decode.
package store_buffer_pkg;

  localparam int SB_ADDR_W = 32;

  localparam logic [3:0] BE_BYTE = 4'b0001;
  localparam logic [3:0] BE_HALF = 4'b0011;
  localparam logic [3:0] BE_WORD = 4'b1111;

  typedef struct packed {
    logic [SB_ADDR_W-1:0] addr;
    logic [3:0]           be;
    logic [31:0]          data;
  } sb_entry_t;

endpackage

// File: rtl/sb_align.sv
// Lane shifter and misalign detector for one core store.
// Purely combinational.
module sb_align
  import store_buffer_pkg::*;
(
  input  logic [1:0]  off,
  input  logic [3:0]  byte_en,
  input  logic [31:0] write_data,
  output logic [3:0]  be_aligned,
  output logic [31:0] data_aligned,
  output logic        legal,
  output logic        misaligned
);

  always_comb begin
    be_aligned   = byte_en << off;
    data_aligned = write_data << {off, 3'b000};
    legal        = 1'b0;
    misaligned   = 1'b0;
    unique case (1'b1)
      (byte_en == BE_BYTE): begin
        legal = 1'b1;
      end
      (byte_en == BE_HALF): begin
        misaligned = (off == 2'd3);
        legal      = !misaligned;
      end
      (byte_en == BE_WORD): begin
        misaligned = (off != 2'd0);
        legal      = !misaligned;
      end
      default: begin
        legal      = 1'b0;
        misaligned = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/store_buffer.sv
// Posted-write FIFO between the core store port and the
// data-memory bus, with sticky overflow/misalign flags.
module store_buffer
  import store_buffer_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 32
) (
  input  logic                       CLOCK,
  input  logic                       RESET_N,
  input  logic                       write_en,
  input  logic [3:0]                 byte_en,
  input  logic [31:0]                write_data,
  input  logic [ADDR_W-1:0]          addr,
  output logic                       full,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       mem_valid,
  input  logic                       mem_ready,
  output logic [ADDR_W-1:0]          mem_addr,
  output logic [3:0]                 mem_be,
  output logic [31:0]                mem_wdata,
  output logic                       overflow,
  output logic                       misaligned,
  input  logic                       clear_err
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  sb_entry_t       mem_q [DEPTH];
  sb_entry_t       head;
  sb_entry_t       new_entry;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            ovf_q, ovf_d;
  logic            mis_q, mis_d;
  logic [3:0]      be_al;
  logic [31:0]     data_al;
  logic            legal, mis_in;
  logic            push, pop, drop_full;

  sb_align u_align (
    .off          (addr[1:0]),
    .byte_en      (byte_en),
    .write_data   (write_data),
    .be_aligned   (be_al),
    .data_aligned (data_al),
    .legal        (legal),
    .misaligned   (mis_in)
  );

  assign full      = (count_q == CW'(DEPTH));
  assign mem_valid = (count_q != '0);
  assign count     = count_q;
  assign head      = mem_q[rd_ptr_q];

  // Storage is not reset, so the bus payload is masked while empty.
  assign mem_addr  = mem_valid ? ADDR_W'(head.addr) : '0;
  assign mem_be    = mem_valid ? head.be : '0;
  assign mem_wdata = mem_valid ? head.data : '0;

  assign overflow   = ovf_q;
  assign misaligned = mis_q;

  always_comb begin
    new_entry      = '0;
    new_entry.addr = SB_ADDR_W'({addr[ADDR_W-1:2], 2'b00});
    new_entry.be   = be_al;
    new_entry.data = data_al;
  end

  always_comb begin
    pop       = mem_valid && mem_ready;
    push      = write_en && legal && (!full || pop);
    drop_full = write_en && legal && full && !pop;
    wr_ptr_d  = wr_ptr_q + PW'(push);
    rd_ptr_d  = rd_ptr_q + PW'(pop);
    count_d   = count_q + CW'(push) - CW'(pop);
    ovf_d     = (ovf_q && !clear_err) || drop_full;
    mis_d     = (mis_q && !clear_err) || (write_en && mis_in);
  end

  always_ff @(posedge CLOCK) begin
    if (!RESET_N) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      mis_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      mis_q    <= mis_d;
    end
  end

  always_ff @(posedge CLOCK) begin
    if (push) begin
      mem_q[wr_ptr_q] <= new_entry;
    end
  end

endmodule
